// File: rtl/stark_decode_queue_pkg.sv
// Shared types for the decode queue: one decoded slot, one stored group entry,
// and the small helpers used by the queue control.
package stark_decode_queue_pkg;

    localparam int DECQ_DEPTH = 8;
    localparam int NSLOT      = 4;
    localparam int PCW        = 64;

    typedef struct packed {
        logic [7:0]  opc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [11:0] imm;
        logic        nop;
    } decode_bus_t;

    localparam int DBW = $bits(decode_bus_t);

    typedef decode_bus_t [NSLOT-1:0] slot_db_t;

    typedef struct packed {
        logic [NSLOT-1:0] slot_v;
        slot_db_t         db;
        logic [PCW-1:0]   pc;
    } decq_entry_t;

    // A slot is worth forwarding to rename only when it is valid and not a NOP.
    function automatic logic [NSLOT-1:0] live_slots(input logic [NSLOT-1:0] slot_v,
                                                    input logic [NSLOT-1:0] nop);
        return slot_v & ~nop;
    endfunction

endpackage

// File: rtl/stark_decode_queue_if.sv
// Group handshake between the decoder (master side) and the queue (slave side),
// carrying both the input group and the head group toward rename.
interface stark_decode_queue_if;
    import stark_decode_queue_pkg::*;

    logic                 in_v;
    logic                 in_rdy;
    logic [NSLOT-1:0]     in_slot_v;
    logic [NSLOT-1:0]     in_nop;
    logic [NSLOT*DBW-1:0] in_db;
    logic [PCW-1:0]       in_pc;

    logic                 out_v;
    logic                 out_rdy;
    logic [NSLOT-1:0]     out_slot_v;
    logic [NSLOT*DBW-1:0] out_db;
    logic [PCW-1:0]       out_pc;

    modport slave (
        input  in_v, in_slot_v, in_nop, in_db, in_pc, out_rdy,
        output in_rdy, out_v, out_slot_v, out_db, out_pc
    );

    modport master (
        output in_v, in_slot_v, in_nop, in_db, in_pc, out_rdy,
        input  in_rdy, out_v, out_slot_v, out_db, out_pc
    );

endinterface

// File: rtl/stark_decq_ram.sv
// Group storage for the decode queue: one synchronous write port and one
// asynchronous read port. Contents are intentionally not reset.
module stark_decq_ram import stark_decode_queue_pkg::*; #(
    parameter int DEPTH = DECQ_DEPTH
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  decq_entry_t              wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output decq_entry_t              rdata_o
);

    decq_entry_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/stark_decode_queue.sv
// Group FIFO between the decoder and rename: drops all-NOP groups, absorbs
// rename back-pressure, flushes in one cycle and counts full-queue stalls.
module stark_decode_queue import stark_decode_queue_pkg::*; #(
    parameter int DEPTH = DECQ_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    stark_decode_queue_if.slave        q_if,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic [31:0]                full_cycles_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [AW-1:0]    head_q, head_d;
    logic [AW-1:0]    tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;
    logic [31:0]      full_cycles_q, full_cycles_d;

    logic             full;
    logic             empty;
    logic             accept;
    logic             push;
    logic             pop;
    logic [NSLOT-1:0] live;
    decq_entry_t      wr_entry;
    decq_entry_t      rd_entry;

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // in_rdy depends only on registered count, never on out_rdy.
    assign q_if.in_rdy = ~full;
    assign accept      = q_if.in_v & ~full;
    assign live        = live_slots(q_if.in_slot_v, q_if.in_nop);
    assign push        = accept & (|live) & ~flush_i;
    assign pop         = ~empty & q_if.out_rdy & ~flush_i;

    always_comb begin
        wr_entry        = '0;
        wr_entry.slot_v = live;
        wr_entry.db     = slot_db_t'(q_if.in_db);
        wr_entry.pc     = q_if.in_pc;
    end

    stark_decq_ram #(.DEPTH(DEPTH)) u_ram (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (tail_q),
        .wdata_i (wr_entry),
        .raddr_i (head_q),
        .rdata_o (rd_entry)
    );

    assign q_if.out_v      = ~empty;
    assign q_if.out_slot_v = rd_entry.slot_v;
    assign q_if.out_db     = rd_entry.db;
    assign q_if.out_pc     = rd_entry.pc;

    always_comb begin
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q;
        full_cycles_d = full_cycles_q;

        if (q_if.in_v && full && !flush_i && (full_cycles_q != '1)) begin
            full_cycles_d = full_cycles_q + 32'd1;
        end

        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) tail_d = tail_q + AW'(1);
            if (pop)  head_d = head_q + AW'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            full_cycles_q <= '0;
        end else begin
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            full_cycles_q <= full_cycles_d;
        end
    end

    assign count_o       = count_q;
    assign full_cycles_o = full_cycles_q;

endmodule

// File: tb/tb_stark_decode_queue.sv
// Self-checking bench for stark_decode_queue: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_stark_decode_queue;
    import stark_decode_queue_pkg::*;

    localparam int DEPTH = DECQ_DEPTH;
    localparam int CW    = $clog2(DEPTH+1);
    localparam int BW    = NSLOT*DBW;

    typedef struct {
        logic [NSLOT-1:0] sv;
        logic [BW-1:0]    db;
        logic [PCW-1:0]   pc;
    } grp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [CW-1:0] count;
    logic [31:0] full_cycles;

    stark_decode_queue_if qif();

    stark_decode_queue #(.DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .flush_i       (flush),
        .q_if          (qif),
        .count_o       (count),
        .full_cycles_o (full_cycles)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    grp_t        mq[$];
    int unsigned m_fc = 0;

    function automatic logic [BW-1:0] rand_db();
        logic [BW-1:0] v;
        for (int k = 0; k < BW; k++) v[k] = 1'($urandom_range(0, 1));
        return v;
    endfunction

    function automatic logic [PCW-1:0] rand_pc();
        return {32'($urandom), 32'($urandom)};
    endfunction

    // Reference: a queue of live groups, advanced with the rules at each edge.
    task automatic model_step();
        logic [NSLOT-1:0] lv;
        bit is_full, do_pop, do_push;
        grp_t g;
        lv      = qif.in_slot_v & ~qif.in_nop;
        is_full = (mq.size() >= DEPTH);
        if (flush) begin
            mq.delete();
        end else begin
            if (qif.in_v && is_full && m_fc != 32'hFFFF_FFFF) m_fc++;
            do_pop  = (mq.size() != 0) && qif.out_rdy;
            do_push = qif.in_v && !is_full && (lv != 0);
            if (do_pop) void'(mq.pop_front());
            if (do_push) begin
                g.sv = lv; g.db = qif.in_db; g.pc = qif.in_pc;
                mq.push_back(g);
            end
        end
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        qif.in_v = 0; qif.in_slot_v = '0; qif.in_nop = '0;
        qif.in_db = '0; qif.in_pc = '0; qif.out_rdy = 0; flush = 0;
    endtask

    task automatic drain();
        qif.in_v = 0; qif.out_rdy = 1;
        for (int i = 0; i < DEPTH + 2; i++) cycle();
        qif.out_rdy = 0;
        n_vec++;
        if (count !== '0) begin
            n_err++; $display("FAIL drain_count: got %0d want 0", count);
        end
    endtask

    task automatic test_reset();
        n_vec++;
        if (qif.out_v !== 1'b0 || count !== '0 || full_cycles !== 32'd0) begin
            n_err++;
            $display("FAIL reset_state: out_v=%b count=%0d fc=%0d want 0/0/0", qif.out_v, count, full_cycles);
        end
        rst = 0;
        @(posedge clk); #1;
        n_vec++;
        if (qif.in_rdy !== 1'b1) begin
            n_err++; $display("FAIL reset_in_rdy: got %b want 1", qif.in_rdy);
        end
    endtask

    task automatic test_single();
        qif.in_v = 1; qif.in_slot_v = 4'b1111; qif.in_nop = 4'b0000;
        qif.in_db = rand_db(); qif.in_pc = 64'h1000; qif.out_rdy = 0;
        #1;
        n_vec++;
        if (qif.out_v !== 1'b0) begin
            n_err++; $display("FAIL single_no_bypass: out_v=%b want 0", qif.out_v);
        end
        cycle();
        qif.in_v = 0;
        n_vec++;
        if (qif.out_v !== 1'b1 || qif.out_slot_v !== 4'b1111 || qif.out_pc !== 64'h1000 ||
            count !== CW'(1) || qif.out_db !== mq[0].db) begin
            n_err++;
            $display("FAIL single_group: out_v=%b slot_v=%b pc=%h count=%0d want 1/1111/1000/1",
                     qif.out_v, qif.out_slot_v, qif.out_pc, count);
        end
        drain();
    endtask

    task automatic test_nop_drop();
        qif.in_v = 1; qif.in_slot_v = 4'b0111; qif.in_nop = 4'b0111;
        qif.in_pc = 64'h2000; qif.out_rdy = 0;
        n_vec++;
        if (qif.in_rdy !== 1'b1) begin
            n_err++; $display("FAIL nop_in_rdy: got %b want 1", qif.in_rdy);
        end
        cycle();
        qif.in_v = 0;
        n_vec++;
        if (count !== '0 || qif.out_v !== 1'b0) begin
            n_err++; $display("FAIL nop_dropped: count=%0d out_v=%b want 0/0", count, qif.out_v);
        end
        qif.in_v = 1; qif.in_slot_v = 4'b1111; qif.in_nop = 4'b0101; qif.in_pc = 64'h2004;
        cycle();
        qif.in_v = 0;
        n_vec++;
        if (qif.out_slot_v !== 4'b1010 || qif.out_pc !== 64'h2004 || count !== CW'(1)) begin
            n_err++;
            $display("FAIL nop_masked: slot_v=%b pc=%h count=%0d want 1010/2004/1", qif.out_slot_v, qif.out_pc, count);
        end
        drain();
    endtask

    task automatic test_fill_stall();
        int unsigned fc0;
        fc0 = full_cycles;
        qif.out_rdy = 0;
        for (int i = 0; i < 10; i++) begin
            qif.in_v = 1; qif.in_slot_v = 4'b1111; qif.in_nop = 4'b0000;
            qif.in_db = rand_db(); qif.in_pc = PCW'(i);
            n_vec++;
            if (qif.in_rdy !== (i < DEPTH)) begin
                n_err++; $display("FAIL fill_in_rdy[%0d]: got %b want %b", i, qif.in_rdy, (i < DEPTH));
            end
            cycle();
        end
        qif.in_v = 0;
        n_vec++;
        if (count !== CW'(DEPTH) || full_cycles !== fc0 + 2) begin
            n_err++; $display("FAIL fill_state: count=%0d fc=%0d want %0d/%0d", count, full_cycles, DEPTH, fc0 + 2);
        end
        qif.out_rdy = 1;
        for (int i = 0; i < DEPTH; i++) begin
            n_vec++;
            if (qif.out_v !== 1'b1 || qif.out_pc !== PCW'(i) || qif.out_db !== mq[0].db) begin
                n_err++; $display("FAIL fill_order[%0d]: out_v=%b pc=%0d want 1/%0d", i, qif.out_v, qif.out_pc, i);
            end
            cycle();
        end
        qif.out_rdy = 0;
        n_vec++;
        if (count !== '0 || qif.out_v !== 1'b0) begin
            n_err++; $display("FAIL fill_empty: count=%0d out_v=%b want 0/0", count, qif.out_v);
        end
    endtask

    task automatic test_wrap();
        logic [PCW-1:0] pcs[20];
        qif.out_rdy = 1;
        for (int i = 0; i < 20; i++) begin
            pcs[i] = rand_pc();
            qif.in_v = 1;
            qif.in_slot_v = 4'($urandom) | 4'b0001;
            qif.in_nop    = 4'($urandom) & 4'b1110;
            qif.in_db = rand_db(); qif.in_pc = pcs[i];
            cycle();
            n_vec++;
            if (count !== CW'(1) || qif.out_pc !== pcs[i] || qif.out_slot_v !== mq[0].sv ||
                qif.out_db !== mq[0].db) begin
                n_err++;
                $display("FAIL wrap[%0d]: count=%0d pc=%h slot_v=%b want 1/%h/%b",
                         i, count, qif.out_pc, qif.out_slot_v, pcs[i], mq[0].sv);
            end
        end
        qif.in_v = 0;
        cycle();
        qif.out_rdy = 0;
        n_vec++;
        if (count !== '0) begin
            n_err++; $display("FAIL wrap_drain: count=%0d want 0", count);
        end
    endtask

    task automatic test_flush();
        qif.out_rdy = 0;
        for (int i = 0; i < 5; i++) begin
            qif.in_v = 1; qif.in_slot_v = 4'b1111; qif.in_nop = 4'b0000;
            qif.in_db = rand_db(); qif.in_pc = rand_pc();
            cycle();
        end
        n_vec++;
        if (count !== CW'(5)) begin
            n_err++; $display("FAIL flush_pre: count=%0d want 5", count);
        end
        qif.in_v = 1; qif.out_rdy = 1; flush = 1; qif.in_pc = 64'hDEAD;
        n_vec++;
        if (qif.in_rdy !== 1'b1) begin
            n_err++; $display("FAIL flush_in_rdy: got %b want 1", qif.in_rdy);
        end
        cycle();
        flush = 0; qif.in_v = 0; qif.out_rdy = 0;
        n_vec++;
        if (count !== '0 || qif.out_v !== 1'b0) begin
            n_err++; $display("FAIL flush_clear: count=%0d out_v=%b want 0/0", count, qif.out_v);
        end
        qif.in_v = 1; qif.in_slot_v = 4'b0011; qif.in_nop = 4'b0000; qif.in_pc = 64'hBEEF;
        cycle();
        qif.in_v = 0;
        n_vec++;
        if (count !== CW'(1) || qif.out_pc !== 64'hBEEF || qif.out_slot_v !== 4'b0011) begin
            n_err++; $display("FAIL flush_next: count=%0d pc=%h slot_v=%b want 1/beef/0011", count, qif.out_pc, qif.out_slot_v);
        end
        drain();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            qif.in_v      = ($urandom_range(0, 3) != 0);
            qif.out_rdy   = ($urandom_range(0, 2) == 0);
            flush         = ($urandom_range(0, 29) == 0);
            qif.in_slot_v = 4'($urandom);
            qif.in_nop    = 4'($urandom);
            qif.in_db     = rand_db();
            qif.in_pc     = rand_pc();
            n_vec++;
            if (qif.in_rdy !== (mq.size() < DEPTH)) begin
                n_err++; $display("FAIL rand_in_rdy[%0d]: got %b want %b", i, qif.in_rdy, (mq.size() < DEPTH));
            end
            cycle();
            n_vec++;
            if (count !== CW'(mq.size()) || qif.out_v !== (mq.size() != 0) || full_cycles !== m_fc) begin
                n_err++;
                $display("FAIL rand_state[%0d]: count=%0d out_v=%b fc=%0d want %0d/%b/%0d",
                         i, count, qif.out_v, full_cycles, mq.size(), (mq.size() != 0), m_fc);
            end
            if (mq.size() != 0) begin
                n_vec++;
                if (qif.out_slot_v !== mq[0].sv || qif.out_pc !== mq[0].pc || qif.out_db !== mq[0].db) begin
                    n_err++;
                    $display("FAIL rand_head[%0d]: slot_v=%b pc=%h want %b/%h", i, qif.out_slot_v, qif.out_pc, mq[0].sv, mq[0].pc);
                end
            end
        end
        idle_inputs();
        drain();
    endtask

    task automatic test_async_reset();
        qif.out_rdy = 0;
        for (int i = 0; i < 3; i++) begin
            qif.in_v = 1; qif.in_slot_v = 4'b1000; qif.in_nop = 4'b0000; qif.in_pc = PCW'(i);
            cycle();
        end
        qif.in_v = 0;
        n_vec++;
        if (count !== CW'(3) || full_cycles === 32'd0) begin
            n_err++; $display("FAIL areset_pre: count=%0d fc=%0d want 3/nonzero", count, full_cycles);
        end
        #2; rst = 1; #1;
        n_vec++;
        if (qif.out_v !== 1'b0 || count !== '0 || full_cycles !== 32'd0) begin
            n_err++;
            $display("FAIL areset_now: out_v=%b count=%0d fc=%0d want 0/0/0", qif.out_v, count, full_cycles);
        end
        mq.delete(); m_fc = 0;
        #1; rst = 0;
        @(posedge clk); #1;
        n_vec++;
        if (qif.in_rdy !== 1'b1 || count !== '0) begin
            n_err++; $display("FAIL areset_after: in_rdy=%b count=%0d want 1/0", qif.in_rdy, count);
        end
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        #3;
        test_reset();
        test_single();
        test_nop_drop();
        test_fill_stall();
        test_wrap();
        test_flush();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/stark_decode_queue.md
Name: stark_decode_queue

Overview:
- Group FIFO between Stark_decoder output and the rename stage.
- Absorbs rename back-pressure so the decoder and extract can keep running.
- Drops decode groups whose valid slots are all NOPs, such as constant-position words marked as NOPs by the decoder.
- Supports a single-cycle pipeline flush on branch miss or exception.

Parameters:
- DEPTH, 8, number of group entries; must be a power of 2 and at least 2.
- NSLOT, 4, decode slots per group; matches the decoder's four constant/NOP positions.
- DBW, $bits(Stark_pkg::decode_bus_t), width of one slot's decode bus.
- PCW, 64, width of the group PC.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous reset, active-high.
- flush  in  1  discard all contents.
- in_v  in  1  upstream group valid.
- in_rdy  out  1  queue can accept a group.
- in_slot_v  in  NSLOT  per-slot valid.
- in_nop  in  NSLOT  per-slot NOP flag, from dbo.nop or mark_nops.
- in_db  in  NSLOT*DBW  decode buses; slot 0 in the LSBs.
- in_pc  in  PCW  group PC.
- out_v  out  1  head group valid.
- out_rdy  in  1  rename accepts the head group.
- out_slot_v  out  NSLOT  head per-slot valid, with NOP slots already masked.
- out_db  out  NSLOT*DBW  head decode buses.
- out_pc  out  PCW  head group PC.
- count  out  $clog2(DEPTH+1)  occupied entries.
- full_cycles  out  32  performance counter of stalls caused by a full queue.

Behaviour:
- Reset (async, rst=1): head, tail and count go to 0; out_v=0; full_cycles=0; in_rdy=1 once reset is released. Storage array contents are not reset. out_db and out_pc are don't-care while out_v=0.
- in_rdy = (count < DEPTH). It is a function of registered state only; there is no combinational path from out_rdy to in_rdy.
- accept = in_v & in_rdy.
- live = in_slot_v & ~in_nop.
- push = accept & (|live) & ~flush. Only pushed groups are stored.
- An accepted group with live==0 is consumed and discarded: no entry is written and count is unchanged.
- A pushed entry stores the slot-valid field as live, so out_slot_v never shows a NOP slot.
- pop = out_v & out_rdy & ~flush.
- out_v = (count != 0). out_slot_v, out_db and out_pc read the head entry combinationally.
- Latency: a group pushed in cycle N is visible at the output in cycle N+1 at the earliest. There is no same-cycle bypass from input to output.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Update rules:
  - push only: tail+1, count+1.
  - pop only: head+1, count-1.
  - push and pop together: both pointers advance; count is unchanged. This is legal at any count < DEPTH, including count==1, where the pushed entry becomes head next cycle.
- Full (count==DEPTH): in_rdy=0. A pop in this cycle frees a slot for the next cycle, not this one.
- Empty (count==0): out_v=0. out_rdy is ignored.
- Flush: next state is head=tail=0, count=0, out_v=0. Any push or pop in the flush cycle is ignored. in_rdy is unaffected during the flush cycle.
- full_cycles increments when in_v & (count==DEPTH) & ~flush, and saturates at 32'hFFFFFFFF. It is not cleared by flush; only rst clears it.
- Reset mid-operation: queue contents are lost immediately (async). Outputs take their reset values within the same cycle.

Decomposition:
- Stark_pkg additions:
  - DECQ_DEPTH constant.
  - decq_entry_t struct: slot_v [NSLOT], db decode_bus_t [NSLOT], pc.
- One natural sub-module, stark_decq_ram: a DEPTH x entry register array with one write port and one asynchronous read port. It keeps the storage separate from pointer and handshake control.
- The control logic (pointers, count, accept/drop, flush, counter) stays in stark_decode_queue.

Test Plan:
- Single group through empty queue: push slot_v=4'b1111, nop=4'b0000, pc=0x1000 in cycle 0 with out_rdy=0 -> cycle 1: out_v=1, out_slot_v=1111, out_pc=0x1000, count=1.
- NOP drop: in_slot_v=4'b0111, in_nop=4'b0111 -> in_rdy=1, count stays 0, out_v stays 0. Then in_slot_v=1111, nop=0101 -> stored out_slot_v=1010.
- Fill and stall: out_rdy=0, 10 back-to-back groups with DEPTH=8 -> count=8, in_rdy=0 from cycle 8, full_cycles increments 2 while in_v is held. Release out_rdy -> groups emerge in order, pc 0..7.
- Wrap-around under concurrent traffic: out_rdy=1 and in_v=1 continuously for 20 groups -> count holds at 1 after the first push, order is preserved across the pointer wrap, no loss or duplication.
- Flush with simultaneous push/pop at count=5 -> next cycle count=0, out_v=0; the flushed-cycle push does not appear; the next push appears alone.
- Async reset asserted between clock edges with count=3 -> out_v=0 and count=0 before the next edge; full_cycles=0.
